ppa_error_monitor: RTL and testbench

Streaming error-metric collector that sits directly downstream of the 16-bit exact and approximate parallel-prefix adders. Each cycle it consumes one pair of 17-bit results, the exact sum and the approximate sum for the same operands, and pipelines an absolute error distance (ED). Over a fixed batch of 2^N_LOG2 samples it accumulates error count, ED sum and maximum ED, then presents the batch results for characterisation runs.

---
 rtl/ppa_eval_pkg.sv | 15 +
 rtl/ppa_abs_diff.sv | 19 +
 rtl/ppa_error_monitor.sv | 122 ++++++++++++
 tb/tb_ppa_error_monitor.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ppa_eval_pkg.sv
// Shared types for parallel-prefix adder evaluation blocks.
package ppa_eval_pkg;

    localparam int unsigned PPA_WIDTH = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ppa_state_e;

    typedef logic [PPA_WIDTH-1:0] ed_t;

endpackage

// File: rtl/ppa_abs_diff.sv
// Unsigned absolute difference |a - b|; the result always fits in WIDTH bits.
module ppa_abs_diff
    import ppa_eval_pkg::*;
#(
    parameter int unsigned WIDTH = PPA_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff_c
);

    // Subtract the smaller operand from the larger so nothing wraps
    always_comb begin
        diff_c = '0;
        if (a >= b) diff_c = a - b;
        else        diff_c = b - a;
    end

endmodule

// File: rtl/ppa_error_monitor.sv
// Batch error-metric collector for exact vs approximate adder results.
module ppa_error_monitor
    import ppa_eval_pkg::*;
#(
    parameter int unsigned WIDTH  = PPA_WIDTH,
    parameter int unsigned N_LOG2 = 10,
    parameter int unsigned ACC_W  = WIDTH + N_LOG2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  exact_sum,
    input  logic [WIDTH-1:0]  approx_sum,
    output logic              busy,
    output logic              done,
    output logic [N_LOG2:0]   err_count,
    output logic [ACC_W-1:0]  sum_ed,
    output logic [WIDTH-1:0]  max_ed,
    output logic [WIDTH-1:0]  mean_ed
);

    localparam int unsigned CNT_W = N_LOG2 + 1;
    localparam int unsigned BATCH = 1 << N_LOG2;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BATCH - 1);

    ppa_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              start_ok;
    logic [WIDTH-1:0]  ed_c;
    logic [WIDTH-1:0]  ed_q;
    logic              neq_q;
    logic              v1_q;

    assign accept   = in_valid && in_ready;
    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign mean_ed  = WIDTH'(sum_ed >> N_LOG2);

    ppa_abs_diff #(.WIDTH(WIDTH)) u_abs_diff (
        .a      (exact_sum),
        .b      (approx_sum),
        .diff_c (ed_c)
    );

    // Control FSM with registered handshake and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_IDX) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    if (start) begin
                        state    <= RUN;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Stage 1: register error distance and its qualifiers
    always_ff @(posedge clk) begin
        if (rst) begin
            ed_q  <= '0;
            neq_q <= 1'b0;
            v1_q  <= 1'b0;
        end else begin
            ed_q  <= ed_c;
            neq_q <= (ed_c != '0);
            v1_q  <= accept;
        end
    end

    // Stage 2: batch accumulators, cleared when a new batch starts
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
        end else if (start_ok) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
        end else if (v1_q) begin
            err_count <= err_count + CNT_W'(neq_q);
            sum_ed    <= sum_ed + ACC_W'(ed_q);
            if (ed_q > max_ed) max_ed <= ed_q;
        end
    end

endmodule

// File: tb/tb_ppa_error_monitor.sv
// Directed self-checking bench for ppa_error_monitor with a batch of 4.
module tb_ppa_error_monitor;

    localparam int unsigned WIDTH  = 17;
    localparam int unsigned N_LOG2 = 2;
    localparam int unsigned ACC_W  = WIDTH + N_LOG2;

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  exact_sum;
    logic [WIDTH-1:0]  approx_sum;
    logic              busy;
    logic              done;
    logic [N_LOG2:0]   err_count;
    logic [ACC_W-1:0]  sum_ed;
    logic [WIDTH-1:0]  max_ed;
    logic [WIDTH-1:0]  mean_ed;

    int checks = 0;
    int errors = 0;

    ppa_error_monitor #(.WIDTH(WIDTH), .N_LOG2(N_LOG2), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .exact_sum  (exact_sum),
        .approx_sum (approx_sum),
        .busy       (busy),
        .done       (done),
        .err_count  (err_count),
        .sum_ed     (sum_ed),
        .max_ed     (max_ed),
        .mean_ed    (mean_ed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_results(input string tag, input logic [31:0] e_cnt, input logic [31:0] e_sum,
                               input logic [31:0] e_max, input logic [31:0] e_mean);
        chk({tag, "_err_count"}, 32'(err_count), e_cnt);
        chk({tag, "_sum_ed"},    32'(sum_ed),    e_sum);
        chk({tag, "_max_ed"},    32'(max_ed),    e_max);
        chk({tag, "_mean_ed"},   32'(mean_ed),   e_mean);
    endtask

    // Present one sample across one rising edge
    task automatic send(input logic [WIDTH-1:0] ex, input logic [WIDTH-1:0] ap);
        in_valid   = 1'b1;
        exact_sum  = ex;
        approx_sum = ap;
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic              pat_v  [8];
    logic [WIDTH-1:0]  pat_ex [8];
    logic [WIDTH-1:0]  pat_ap [8];

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        exact_sum = '0; approx_sum = '0;

        // Reset held two cycles, valid pulses during reset ignored
        @(negedge clk);
        in_valid = 1'b1; exact_sum = 17'h00007; approx_sum = 17'h00001;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy",     32'(busy),     0);
        chk("rst_done",     32'(done),     0);
        chk_results("rst", 0, 0, 0, 0);
        rst = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("idle_in_ready", 32'(in_ready), 0);
        chk("idle_err_count", 32'(err_count), 0);
        chk("idle_sum_ed", 32'(sum_ed), 0);

        // Exact match batch: done on the 6th cycle counted from the start cycle
        do_start();
        chk("run_in_ready", 32'(in_ready), 1);
        chk("run_busy",     32'(busy),     1);
        for (int i = 0; i < 4; i++) send(17'h0FFFF, 17'h0FFFF);
        in_valid = 1'b0;
        chk("drain_done",     32'(done),     0);
        chk("drain_busy",     32'(busy),     1);
        chk("drain_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        chk("match_done", 32'(done), 1);
        chk("match_busy", 32'(busy), 0);
        chk_results("match", 0, 0, 0, 0);

        // Mixed errors of both signs
        do_start();
        send(17'h00005, 17'h00004);
        send(17'h00003, 17'h00005);
        send(17'h00123, 17'h00123);
        send(17'h1FFFE, 17'h0FFFE);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mixed_done", 32'(done), 1);
        chk_results("mixed", 3, 32'h10003, 32'h10000, 32'h04000);

        // Gapped valid, overrun samples, start during RUN
        pat_v  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        pat_ex = '{17'd10, 17'd99, 17'd0, 17'd20, 17'd77, 17'd8, 17'd0, 17'h1FFFF};
        pat_ap = '{17'd9,  17'd0,  17'd2, 17'd16, 17'd0,  17'd0, 17'h1FFFF, 17'd0};
        do_start();
        for (int i = 0; i < 8; i++) begin
            in_valid   = pat_v[i];
            exact_sum  = pat_ex[i];
            approx_sum = pat_ap[i];
            start      = (i == 1);
            if (i == 5) chk("gap_ready_before_last", 32'(in_ready), 1);
            if (i == 6) chk("gap_ready_after_last",  32'(in_ready), 0);
            @(negedge clk);
        end
        in_valid = 1'b0; start = 1'b0;
        chk("gap_done", 32'(done), 1);
        chk_results("gap", 4, 15, 8, 3);

        // Reset mid-batch, asserted together with start
        do_start();
        send(17'd10, 17'd5);
        send(17'd5, 17'd10);
        in_valid = 1'b0;
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("midrst_busy",     32'(busy),     0);
        chk("midrst_done",     32'(done),     0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        chk_results("midrst", 0, 0, 0, 0);
        @(negedge clk);
        chk("midrst_still_idle", 32'(busy), 0);
        do_start();
        send(17'd10, 17'd7);
        send(17'd7, 17'd10);
        send(17'h1FFFF, 17'h1FFFC);
        send(17'd3, 17'd0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("ed3_done", 32'(done), 1);
        chk_results("ed3", 4, 12, 3, 3);

        // Back-to-back: start in DONE clears, second batch independent
        do_start();
        chk("b2b_done", 32'(done), 0);
        chk("b2b_busy", 32'(busy), 1);
        chk_results("b2b_clear", 0, 0, 0, 0);
        send(17'h1FFFF, 17'h00000);
        send(17'h00042, 17'h00042);
        send(17'h00000, 17'h00001);
        send(17'h10000, 17'h10000);
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_final_done", 32'(done), 1);
        chk_results("b2b", 2, 32'h20000, 32'h1FFFF, 32'h08000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
